// File: rtl/icache_refill_ctrl_pkg.sv
// Shared widths, address field positions and one-hot FSM encoding for the
// instruction-cache refill controller.
package icache_refill_ctrl_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned TAG_W      = 24;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;

    // Byte address layout: {tag[31:8], idx[7:5], word[4:2], byte[1:0]}
    localparam int unsigned WOFF_LSB = 2;
    localparam int unsigned IDX_LSB  = WOFF_LSB + OFF_W;
    localparam int unsigned TAG_LSB  = IDX_LSB + IDX_W;

    localparam int unsigned NUM_STATES = 7;

    typedef enum logic [NUM_STATES-1:0] {
        StWait    = 7'b000_0001,
        StTagRd   = 7'b000_0010,
        StCacheRd = 7'b000_0100,
        StMemReq  = 7'b000_1000,
        StRecv    = 7'b001_0000,
        StRefill  = 7'b010_0000,
        StResp    = 7'b100_0000
    } state_t;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Beat assembler for one cache line: stores incoming words at the running beat
// index and presents the whole line as a flat vector, word k at [32k+31:32k].
module icache_line_buf
    import icache_refill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wen,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] line
);

    logic [WORD_W-1:0] slot_q [LINE_WORDS];
    logic [OFF_W-1:0]  cnt_q;

    // Clearing only rewinds the counter; slots keep old words so a short burst
    // leaves the unreceived part of the line as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                slot_q[k] <= '0;
            end
        end else if (clr) begin
            cnt_q <= '0;
        end else if (wen) begin
            slot_q[cnt_q] <= wdata;
            cnt_q         <= cnt_q + OFF_W'(1);
        end
    end

    always_comb begin
        line = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            line[k*WORD_W +: WORD_W] = slot_q[k];
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped I-cache lookup and line refill controller.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              from_cpu_req_valid,
    input  logic [ADDR_W-1:0] from_cpu_req_addr,
    output logic              to_cpu_req_ready,
    output logic              to_cpu_rsp_valid,
    output logic [WORD_W-1:0] to_cpu_rsp_data,
    input  logic              from_cpu_rsp_ready,
    output logic [IDX_W-1:0]  tag_raddr,
    input  logic [TAG_W-1:0]  tag_rdata,
    input  logic              tag_vsignal,
    output logic              tag_wen,
    output logic [IDX_W-1:0]  tag_waddr,
    output logic [TAG_W-1:0]  tag_wdata,
    output logic [IDX_W-1:0]  data_raddr,
    input  logic [LINE_W-1:0] data_rdata,
    output logic              data_wen,
    output logic [IDX_W-1:0]  data_waddr,
    output logic [LINE_W-1:0] data_wdata,
    output logic              to_mem_rd_req_valid,
    output logic [ADDR_W-1:0] to_mem_rd_req_addr,
    input  logic              from_mem_rd_req_ready,
    input  logic              from_mem_rd_rsp_valid,
    input  logic [WORD_W-1:0] from_mem_rd_rsp_data,
    input  logic              from_mem_rd_rsp_last,
    output logic              to_mem_rd_rsp_ready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] rsp_q, rsp_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_woff;
    logic              hit;

    logic              buf_clr;
    logic              buf_wen;
    logic [LINE_W-1:0] buf_line;

    logic              unused_addr_lsb;

    assign req_tag         = addr_q[TAG_LSB +: TAG_W];
    assign req_idx         = addr_q[IDX_LSB +: IDX_W];
    assign req_woff        = addr_q[WOFF_LSB +: OFF_W];
    assign unused_addr_lsb = ^addr_q[WOFF_LSB-1:0];

    assign hit = tag_vsignal & (tag_rdata == req_tag);

    icache_line_buf u_line_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (buf_clr),
        .wen   (buf_wen),
        .wdata (from_mem_rd_rsp_data),
        .line  (buf_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWait;
            addr_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        rsp_d               = rsp_q;
        to_cpu_req_ready    = 1'b0;
        to_cpu_rsp_valid    = 1'b0;
        tag_wen             = 1'b0;
        data_wen            = 1'b0;
        to_mem_rd_req_valid = 1'b0;
        to_mem_rd_rsp_ready = 1'b0;
        buf_clr             = 1'b0;
        buf_wen             = 1'b0;

        unique case (state_q)
            StWait: begin
                to_cpu_req_ready = 1'b1;
                if (from_cpu_req_valid) begin
                    addr_d  = from_cpu_req_addr;
                    state_d = StTagRd;
                end
            end
            StTagRd: begin
                state_d = hit ? StCacheRd : StMemReq;
            end
            StCacheRd: begin
                rsp_d   = line_word(data_rdata, req_woff);
                state_d = StResp;
            end
            StMemReq: begin
                to_mem_rd_req_valid = 1'b1;
                if (from_mem_rd_req_ready) begin
                    buf_clr = 1'b1;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                to_mem_rd_rsp_ready = 1'b1;
                if (from_mem_rd_rsp_valid) begin
                    buf_wen = 1'b1;
                    // An early last still refills; missing slots keep stale data.
                    if (from_mem_rd_rsp_last) begin
                        state_d = StRefill;
                    end
                end
            end
            StRefill: begin
                tag_wen  = 1'b1;
                data_wen = 1'b1;
                rsp_d    = line_word(buf_line, req_woff);
                state_d  = StResp;
            end
            StResp: begin
                to_cpu_rsp_valid = 1'b1;
                if (from_cpu_rsp_ready) begin
                    state_d = StWait;
                end
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    assign to_cpu_rsp_data    = rsp_q;
    assign tag_raddr          = req_idx;
    assign data_raddr         = req_idx;
    assign tag_waddr          = req_idx;
    assign tag_wdata          = req_tag;
    assign data_waddr         = req_idx;
    assign data_wdata         = buf_line;
    assign to_mem_rd_req_addr = {req_tag, req_idx, {IDX_LSB{1'b0}}};

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StTagRd) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
